// File: rtl/mpu_matrix_loader_if.sv
// ============================================================================
// Module   : mpu_matrix_loader_if
// Brief    : Element stream in / flattened matrix out bundle for the loader.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mpu_matrix_loader_if #(
  parameter int W   = 8,
  parameter int DIM = 5,
  parameter int CW  = 5
) ();

  logic [W-1:0]         in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic                 abort;
  logic [W*DIM*DIM-1:0] matrix_out;
  logic                 matrix_valid;
  logic                 matrix_ready;
  logic [CW-1:0]        count;

  modport master (
    output in_data, in_valid, abort, matrix_ready,
    input  in_ready, matrix_out, matrix_valid, count
  );

  modport slave (
    input  in_data, in_valid, abort, matrix_ready,
    output in_ready, matrix_out, matrix_valid, count
  );

endinterface

`default_nettype wire

// File: rtl/mpu_matrix_loader.sv
// ============================================================================
// Module   : mpu_matrix_loader
// Brief    : Assembles a serial stream of W-bit elements into a DIMxDIM matrix.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mpu_matrix_loader #(
  parameter int W   = 8,
  parameter int DIM = 5,
  parameter int CW  = 5
) (
  input  wire                  clk,
  input  wire                  rst_n,
  mpu_matrix_loader_if.slave   bus
);

  localparam int            C_NELEM = DIM * DIM;
  localparam logic [CW-1:0] C_LAST  = CW'(C_NELEM - 1);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          count_q, count_d;
  logic [W*C_NELEM-1:0]   mat_q, mat_d;
  logic                   w_in_ready;
  logic                   w_accept;

  assign w_in_ready = (state_q == FILL) && !bus.abort;
  assign w_accept   = w_in_ready && bus.in_valid;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    mat_d   = mat_q;
    case (state_q)
      FILL: begin
        if (bus.abort) begin
          count_d = '0;
        end else if (w_accept) begin
          // Decode the slot explicitly so the write index can never leave the vector.
          for (int k = 0; k < C_NELEM; k++) begin
            if (count_q == CW'(k)) begin
              mat_d[W*k +: W] = bus.in_data;
            end
          end
          count_d = count_q + CW'(1);
          if (count_q == C_LAST) begin
            state_d = FULL;
          end
        end
      end
      FULL: begin
        if (bus.abort || bus.matrix_ready) begin
          state_d = FILL;
          count_d = '0;
        end
      end
      default: begin
        state_d = FILL;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      count_q <= '0;
      mat_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mat_q   <= mat_d;
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.matrix_out   = mat_q;
  assign bus.matrix_valid = (state_q == FULL);
  assign bus.count        = count_q;

endmodule

`default_nettype wire

// File: tb/tb_mpu_matrix_loader.sv
// ============================================================================
// Module   : tb_mpu_matrix_loader
// Brief    : Randomized self-checking bench for mpu_matrix_loader.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mpu_matrix_loader;

  localparam int W   = 8;
  localparam int DIM = 5;
  localparam int CW  = 5;
  localparam int N   = DIM * DIM;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mpu_matrix_loader_if #(.W(W), .DIM(DIM), .CW(CW)) bus ();

  mpu_matrix_loader #(.W(W), .DIM(DIM), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference: an array of slots, a fill count and a "matrix is complete" flag.
  logic [W-1:0] m_slot [N];
  int           m_cnt;
  bit           m_full;

  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  int  n_acc    = 0;
  int  rise_cyc = -1;
  bit  prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] m_matrix();
    logic [255:0] r = '0;
    for (int k = 0; k < N; k++) r[W*k +: W] = m_slot[k];
    return r;
  endfunction

  task automatic model_reset();
    m_cnt  = 0;
    m_full = 1'b0;
    for (int k = 0; k < N; k++) m_slot[k] = '0;
  endtask

  // One clock: drive, check in_ready, advance the model, check registered outputs.
  task automatic step(input bit v, input logic [W-1:0] d, input bit ab, input bit mr);
    bit acc;
    bus.in_valid     = v;
    bus.in_data      = d;
    bus.abort        = ab;
    bus.matrix_ready = mr;
    #1;
    check_eq("in_ready", {255'd0, bus.in_ready}, {255'd0, (!m_full && !ab)});
    acc = !m_full && !ab && v;
    @(posedge clk);
    if (ab) begin
      m_cnt  = 0;
      m_full = 1'b0;
    end else if (acc) begin
      m_slot[m_cnt] = d;
      m_cnt++;
      n_acc++;
      if (m_cnt == N) m_full = 1'b1;
    end else if (m_full && mr) begin
      m_cnt  = 0;
      m_full = 1'b0;
    end
    @(negedge clk);
    check_eq("count", {251'd0, bus.count}, 256'(m_cnt));
    check_eq("matrix_valid", {255'd0, bus.matrix_valid}, {255'd0, m_full});
    check_eq("matrix_out", {56'd0, bus.matrix_out}, m_matrix());
    if (bus.matrix_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = bus.matrix_valid;
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) step(1'b1, W'($urandom), 1'b0, 1'b0);
  endtask

  task automatic async_reset_check(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check_eq({tag, "_valid"}, {255'd0, bus.matrix_valid}, 256'd0);
    check_eq({tag, "_count"}, {251'd0, bus.count}, 256'd0);
    check_eq({tag, "_matrix"}, {56'd0, bus.matrix_out}, 256'd0);
    model_reset();
    prev_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [W-1:0] pat [N];
  int r1, r2, guard;
  bit tog;

  initial begin
    model_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.abort = 1'b0; bus.matrix_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_valid", {255'd0, bus.matrix_valid}, 256'd0);
    check_eq("rst_count", {251'd0, bus.count}, 256'd0);
    check_eq("rst_matrix", {56'd0, bus.matrix_out}, 256'd0);
    rst_n = 1'b1;

    // Stream 1..25 back to back, then hold FULL with in_valid high.
    for (int i = 1; i <= N; i++) step(1'b1, W'(i), 1'b0, 1'b0);
    check_eq("t1_slot0", {248'd0, bus.matrix_out[7:0]}, 256'd1);
    check_eq("t1_slot1", {248'd0, bus.matrix_out[15:8]}, 256'd2);
    check_eq("t1_slot24", {248'd0, bus.matrix_out[199:192]}, 256'd25);
    check_eq("t1_count", {251'd0, bus.count}, 256'd25);
    for (int i = 0; i < 10; i++) step(1'b1, W'($urandom), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);

    // Signed pattern with in_valid toggling.
    pat[0] = 8'd2; pat[1] = 8'hFF; pat[2] = 8'd0; pat[3] = 8'd4;
    pat[4] = 8'd5; pat[5] = 8'd12; pat[6] = 8'd7;
    for (int k = 7; k < N - 1; k++) pat[k] = W'($urandom);
    pat[N-1] = 8'd1;
    n_acc = 0; tog = 1'b1; guard = 0;
    while (n_acc < N && guard < 200) begin
      step(tog, pat[n_acc], 1'b0, 1'b0);
      tog = !tog;
      guard++;
    end
    step(1'b0, '0, 1'b0, 1'b0);
    check_eq("t2_accepts", 256'(n_acc), 256'(N));
    check_eq("t2_slot1", {248'd0, bus.matrix_out[15:8]}, 256'hFF);
    check_eq("t2_slot24", {248'd0, bus.matrix_out[199:192]}, 256'd1);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);

    // Abort mid-fill together with a valid element.
    fill_random(10);
    step(1'b1, 8'd99, 1'b1, 1'b0);
    check_eq("t3_count", {251'd0, bus.count}, 256'd0);
    fill_random(N);
    step(1'b0, '0, 1'b0, 1'b0);

    // Abort and matrix_ready in the same cycle while FULL.
    step(1'b0, '0, 1'b1, 1'b1);
    check_eq("t4_valid", {255'd0, bus.matrix_valid}, 256'd0);

    // Asynchronous reset mid-fill and while FULL.
    fill_random(13);
    async_reset_check("t5a");
    fill_random(N);
    step(1'b0, '0, 1'b0, 1'b0);
    async_reset_check("t5b");

    // Back-to-back matrices.
    fill_random(N);
    r1 = rise_cyc;
    step(1'b0, '0, 1'b0, 1'b1);
    fill_random(N);
    r2 = rise_cyc;
    check_eq("t6_gap", {255'd0, (r2 - r1) >= N + 1}, 256'd1);
    step(1'b0, '0, 1'b0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), W'($urandom), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 2) == 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
